serial_frame_demux: RTL and testbench

- Parametrised serial frame receiver and router; next generation of the team's single-wire 4-lane stream demux.
- Each frame on `sin` carries, in order:
  - a start bit;
  - a header with destination address and payload length;
  - a payload, which the block routes bit-by-bit onto one of NCH output lanes;
  - a mandatory stop bit.
- Adds over the previous generation:
  - generic lane count and length widths;
  - stop-bit checking;
  - zero-length frames;
  - a frame-done pulse;
  - deterministic 0 on unselected lanes instead of tristate.

---
 rtl/serial_frame_demux.sv | 120 ++++++++++++
 tb/tb_serial_frame_demux.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/serial_frame_demux.sv
// Serial frame receiver: start bit, LSB-first {len,addr} header, payload routed
// onto one of NCH lanes, then a checked stop bit.
module serial_frame_demux #(
   parameter int ADDR_W  = 2,
   parameter int LEN_W   = 6,
   parameter int SCALE_W = 3,
   localparam int NCH    = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sin,
   output logic [NCH-1:0]    dout,
   output logic [ADDR_W-1:0] dest,
   output logic [LEN_W-1:0]  len,
   output logic              valid,
   output logic              busy,
   output logic              frame_done,
   output logic              error
);

   localparam int HDR_W  = ADDR_W + LEN_W;
   localparam int CNT_W  = LEN_W + SCALE_W;
   localparam int HCNT_W = $clog2(HDR_W + 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HDR  = 3'd1;
   localparam logic [2:0] S_PAY  = 3'd2;
   localparam logic [2:0] S_STOP = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [HDR_W-2:0]  hdr_q, hdr_d;
   logic [HCNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0]  pcnt_q, pcnt_d;
   logic [ADDR_W-1:0] dest_q, dest_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              done_q, done_d;
   logic [HDR_W-1:0]  hdr_asm;

   // Only HDR_W-1 bits are stored; the final header bit is taken straight from sin.
   assign hdr_asm = {sin, hdr_q};

   always_comb begin
      state_d = state_q;
      hdr_d   = hdr_q;
      hcnt_d  = hcnt_q;
      pcnt_d  = pcnt_q;
      dest_d  = dest_q;
      len_d   = len_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!sin) begin
               state_d = S_HDR;
               hcnt_d  = '0;
            end
         end
         S_HDR: begin
            hdr_d  = hdr_asm[HDR_W-1:1];
            hcnt_d = hcnt_q + 1'b1;
            if (hcnt_q == HCNT_W'(HDR_W - 1)) begin
               dest_d  = hdr_asm[ADDR_W-1:0];
               len_d   = hdr_asm[HDR_W-1 -: LEN_W];
               pcnt_d  = {hdr_asm[HDR_W-1 -: LEN_W], {SCALE_W{1'b0}}};
               state_d = (hdr_asm[HDR_W-1 -: LEN_W] != '0) ? S_PAY : S_STOP;
            end
         end
         S_PAY: begin
            pcnt_d = pcnt_q - 1'b1;
            if (pcnt_q == CNT_W'(1)) state_d = S_STOP;
         end
         S_STOP: begin
            if (sin) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_ERR;
            end
         end
         S_ERR: begin
            if (sin) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         hdr_q   <= '0;
         hcnt_q  <= '0;
         pcnt_q  <= '0;
         dest_q  <= '0;
         len_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hdr_q   <= hdr_d;
         hcnt_q  <= hcnt_d;
         pcnt_q  <= pcnt_d;
         dest_q  <= dest_d;
         len_q   <= len_d;
         done_q  <= done_d;
      end
   end

   // Payload passes through combinationally; unselected lanes are driven 0.
   always_comb begin
      dout = '0;
      if (state_q == S_PAY) dout[dest_q] = sin;
   end

   assign dest       = dest_q;
   assign len        = len_q;
   assign valid      = (state_q == S_PAY);
   assign busy       = (state_q != S_IDLE);
   assign frame_done = done_q;
   assign error      = (state_q == S_ERR);

endmodule

// File: tb/tb_serial_frame_demux.sv
// Bench for serial_frame_demux: frames are described at the protocol level and
// expanded into per-cycle expected outputs, then compared cycle by cycle.
module tb_serial_frame_demux;

   localparam int ADDR_W  = 2;
   localparam int LEN_W   = 6;
   localparam int SCALE_W = 3;
   localparam int NCH     = 4;
   localparam int OUT_W   = NCH + ADDR_W + LEN_W + 4;

   logic              clk;
   logic              rst_n;
   logic              sin;
   logic [NCH-1:0]    dout;
   logic [ADDR_W-1:0] dest;
   logic [LEN_W-1:0]  len;
   logic              valid;
   logic              busy;
   logic              frame_done;
   logic              error;

   serial_frame_demux #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .SCALE_W(SCALE_W)) dut (
      .clk(clk), .rst_n(rst_n), .sin(sin), .dout(dout), .dest(dest), .len(len),
      .valid(valid), .busy(busy), .frame_done(frame_done), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   bit              sin_q[$];
   logic [OUT_W-1:0] exp_q[$];
   logic [ADDR_W-1:0] cur_dest;
   logic [LEN_W-1:0]  cur_len;
   bit                pend_done;

   function automatic logic [OUT_W-1:0] observed();
      return {dout, dest, len, valid, busy, frame_done, error};
   endfunction

   // One bus cycle: the line value and what the outputs must show during it.
   function automatic void push(bit s, bit v, bit b, bit e);
      logic [NCH-1:0] d;
      d = v ? (NCH'(s) << cur_dest) : '0;
      sin_q.push_back(s);
      exp_q.push_back({d, cur_dest, cur_len, v, b, pend_done, e});
      pend_done = 1'b0;
   endfunction

   function automatic void add_idle(int n);
      for (int i = 0; i < n; i++) push(1'b1, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic void add_frame(int d, int l, bit stop_ok, int err_zeros,
                                     bit fixed, logic [7:0] pat);
      logic [ADDR_W+LEN_W-1:0] hv;
      bit b;
      hv = {LEN_W'(l), ADDR_W'(d)};
      push(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < ADDR_W + LEN_W; i++) push(hv[i], 1'b0, 1'b1, 1'b0);
      cur_dest = ADDR_W'(d);
      cur_len  = LEN_W'(l);
      for (int i = 0; i < l * (1 << SCALE_W); i++) begin
         b = fixed ? pat[7 - (i % 8)] : 1'($urandom_range(0, 1));
         push(b, 1'b1, 1'b1, 1'b0);
      end
      if (stop_ok) begin
         push(1'b1, 1'b0, 1'b1, 1'b0);
         pend_done = 1'b1;
      end else begin
         push(1'b0, 1'b0, 1'b1, 1'b0);
         for (int i = 0; i < err_zeros; i++) push(1'b0, 1'b0, 1'b1, 1'b1);
         push(1'b1, 1'b0, 1'b1, 1'b1);
      end
   endfunction

   // Drives the first n queued cycles (all if n < 0), then drops the queue.
   task automatic run(input int n);
      int cnt;
      logic [OUT_W-1:0] got;
      cnt = (n < 0 || n > sin_q.size()) ? sin_q.size() : n;
      for (int i = 0; i < cnt; i++) begin
         @(posedge clk);
         #1 sin = sin_q[i];
         @(negedge clk);
         got = observed();
         vectors++;
         assert (got === exp_q[i]) else begin
            miscompares++;
            $error("FAIL cyc%0d {dout,dest,len,valid,busy,done,err} observed=%b expected=%b",
                   i, got, exp_q[i]);
         end
      end
      sin_q.delete();
      exp_q.delete();
   endtask

   task automatic check_zero(input string tag);
      logic [OUT_W-1:0] got;
      got = observed();
      vectors++;
      assert (got === '0) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, got, {OUT_W{1'b0}});
      end
   endtask

   initial begin
      cur_dest  = '0;
      cur_len   = '0;
      pend_done = 1'b0;
      sin   = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      add_frame(2, 1, 1'b1, 0, 1'b1, 8'b10110010);
      add_frame(0, 3, 1'b1, 0, 1'b0, 8'h00);
      add_frame(3, 0, 1'b1, 0, 1'b0, 8'h00);
      add_frame(1, 1, 1'b0, 5, 1'b0, 8'h00);
      add_idle(2);
      add_frame(2, 2, 1'b1, 0, 1'b0, 8'h00);
      add_frame(1, 1, 1'b1, 0, 1'b0, 8'h00);
      add_idle(2);
      run(-1);

      for (int f = 0; f < 8; f++) begin
         add_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                   ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), 1'b0, 8'h00);
         add_idle(int'($urandom_range(0, 2)));
      end
      add_idle(1);
      run(-1);

      // Reset pulse in the middle of a payload.
      add_frame(1, 2, 1'b1, 0, 1'b0, 8'h00);
      run(1 + ADDR_W + LEN_W + 5);
      #1 rst_n = 1'b0;
      sin = 1'b1;
      #1 check_zero("async_reset_midpay");
      @(posedge clk);
      #1 rst_n = 1'b1;
      cur_dest  = '0;
      cur_len   = '0;
      pend_done = 1'b0;
      add_idle(1);
      add_frame(3, 1, 1'b1, 0, 1'b0, 8'h00);
      add_idle(2);
      run(-1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
